// File: rtl/seg7_scan_decoder.sv
// Readback decoder for a multiplexed 7-segment bus: waits for each {an,seg}
// pattern to settle, decodes it to a hex nibble and assembles full frames.
module seg7_scan_decoder #(
    parameter int NDIG   = 4,
    parameter int STABLE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg,
    input  logic [NDIG-1:0]     an,
    output logic [4*NDIG-1:0]   value,
    output logic [NDIG-1:0]     digit_ok,
    output logic                frame_valid,
    output logic                err,
    output logic [2:0]          err_digit
);

    localparam logic [7:0] STABLE_C  = 8'(STABLE);
    localparam logic [7:0] STABLE_M1 = 8'(STABLE - 1);

    logic [NDIG+6:0]   smp_q, smp_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [NDIG-1:0]   mask_q, mask_d, mask_new;
    logic [4*NDIG-1:0] value_q, value_d;
    logic [NDIG-1:0]   ok_q, ok_d;
    logic              frame_q, frame_d;
    logic              err_q, err_d;
    logic [2:0]        err_digit_q, err_digit_d;
    logic [NDIG+6:0]   sample_w;
    logic              capture;
    logic [4:0]        dec;
    int                idx;

    // Returns {valid, nibble}; anything outside the hex font is invalid.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h3F: decode = 5'h10;
            7'h06: decode = 5'h11;
            7'h5B: decode = 5'h12;
            7'h4F: decode = 5'h13;
            7'h66: decode = 5'h14;
            7'h6D: decode = 5'h15;
            7'h7D: decode = 5'h16;
            7'h07: decode = 5'h17;
            7'h7F: decode = 5'h18;
            7'h6F: decode = 5'h19;
            7'h77: decode = 5'h1A;
            7'h7C: decode = 5'h1B;
            7'h39: decode = 5'h1C;
            7'h5E: decode = 5'h1D;
            7'h79: decode = 5'h1E;
            7'h71: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    always_comb begin
        sample_w    = {an, seg};
        smp_d       = sample_w;
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        mask_new    = mask_q;
        value_d     = value_q;
        ok_d        = ok_q;
        frame_d     = 1'b0;
        err_d       = 1'b0;
        err_digit_d = err_digit_q;
        idx         = 0;
        dec         = decode(seg);

        if (sample_w != smp_q)
            cnt_d = 8'd1;
        else if (cnt_q != STABLE_C)
            cnt_d = cnt_q + 8'd1;

        for (int k = 0; k < NDIG; k++)
            if (an[k]) idx = k;

        // Fires only on the STABLE-1 -> STABLE step, so once per stable interval.
        capture = (sample_w == smp_q) && (cnt_q == STABLE_M1) && $onehot(an);

        if (capture) begin
            if (dec[4]) begin
                value_d[4*idx +: 4] = dec[3:0];
                ok_d[idx]           = 1'b1;
                mask_new[idx]       = 1'b1;
                if (&mask_new) begin
                    frame_d = 1'b1;
                    mask_d  = '0;
                end else begin
                    mask_d  = mask_new;
                end
            end else begin
                ok_d[idx]   = 1'b0;
                mask_d[idx] = 1'b0;
                err_d       = 1'b1;
                err_digit_d = idx[2:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_q       <= '0;
            cnt_q       <= '0;
            mask_q      <= '0;
            value_q     <= '0;
            ok_q        <= '0;
            frame_q     <= 1'b0;
            err_q       <= 1'b0;
            err_digit_q <= '0;
        end else begin
            smp_q       <= smp_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            value_q     <= value_d;
            ok_q        <= ok_d;
            frame_q     <= frame_d;
            err_q       <= err_d;
            err_digit_q <= err_digit_d;
        end
    end

    assign value       = value_q;
    assign digit_ok    = ok_q;
    assign frame_valid = frame_q;
    assign err         = err_q;
    assign err_digit   = err_digit_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (NDIG=4, STABLE=4); expected values
// are hand-computed from the segment font and capture timing.
module tb_seg7_scan_decoder;

    logic        clk;
    logic        rst;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] value;
    logic [3:0]  digit_ok;
    logic        frame_valid;
    logic        err;
    logic [2:0]  err_digit;

    int checks = 0;
    int passes = 0;
    int fcnt   = 0;
    int ecnt   = 0;
    int fat    = 0;

    seg7_scan_decoder #(.NDIG(4), .STABLE(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg         (seg),
        .an          (an),
        .value       (value),
        .digit_ok    (digit_ok),
        .frame_valid (frame_valid),
        .err         (err),
        .err_digit   (err_digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive a pattern for n edges, tallying pulses; fat = edge number of the last frame pulse.
    task automatic run(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (frame_valid === 1'b1) begin
                fcnt++;
                fat = i + 1;
            end
            if (err === 1'b1) ecnt++;
            if (frame_valid === 1'b1 && err === 1'b1) check("frame_err_overlap", 1, 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        an  = 4'b0000;
        seg = 7'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_value", value, 16'h0000);
        check("rst_ok", digit_ok, 4'h0);
        check("rst_frame", frame_valid, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_err_digit", err_digit, 3'd0);
        rst = 1'b0;

        // First capture latency: nothing before the 4th edge
        an  = 4'b0001;
        seg = 7'h06;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("lat_value_early", value, 16'h0000);
        check("lat_ok_early", digit_ok, 4'h0);
        @(posedge clk);
        #1;
        check("lat_value", value, 16'h0001);
        check("lat_ok", digit_ok, 4'h1);
        check("lat_frame", frame_valid, 1'b0);

        // Full scan 0..3
        fcnt = 0;
        run(4'b0001, 7'h3F, 6);
        run(4'b0010, 7'h4F, 6);
        run(4'b0100, 7'h7D, 6);
        check("scan_frame_early", fcnt, 0);
        fat = 0;
        run(4'b1000, 7'h71, 6);
        check("scan_value", value, 16'hF630);
        check("scan_ok", digit_ok, 4'hF);
        check("scan_frame_cnt", fcnt, 1);
        check("scan_frame_edge", fat, 4);

        // Invalid pattern on digit 1
        fcnt = 0;
        ecnt = 0;
        run(4'b0010, 7'h00, 5);
        check("inv_err_cnt", ecnt, 1);
        check("inv_err_digit", err_digit, 3'd1);
        check("inv_ok", digit_ok, 4'hD);
        check("inv_value", value, 16'hF630);
        run(4'b0100, 7'h7D, 6);
        run(4'b1000, 7'h71, 6);
        check("inv_no_frame", fcnt, 0);
        run(4'b0001, 7'h3F, 6);
        fat = 0;
        run(4'b0010, 7'h06, 6);
        check("rescan_frame_cnt", fcnt, 1);
        check("rescan_frame_edge", fat, 4);
        check("rescan_value", value, 16'hF610);
        check("rescan_ok", digit_ok, 4'hF);

        // Multi-hot and blanked selects are ignored
        fcnt = 0;
        ecnt = 0;
        run(4'b0011, 7'h3F, 10);
        run(4'b0000, 7'h3F, 10);
        check("sel_err", ecnt, 0);
        check("sel_frame", fcnt, 0);
        check("sel_value", value, 16'hF610);
        check("sel_ok", digit_ok, 4'hF);

        // Toggling faster than STABLE never captures
        run(4'b0001, 7'h06, 3);
        run(4'b0001, 7'h5B, 3);
        run(4'b0001, 7'h06, 3);
        run(4'b0001, 7'h5B, 3);
        run(4'b0001, 7'h06, 3);
        check("tog_value", value, 16'hF610);
        check("tog_err", ecnt, 0);
        run(4'b0001, 7'h5B, 3);
        check("hold_value_early", value, 16'hF610);
        run(4'b0001, 7'h5B, 1);
        check("hold_value", value, 16'hF612);
        check("hold_frame", fcnt, 0);

        // Reset mid-frame discards partial mask
        run(4'b0010, 7'h06, 6);
        check("pre_rst_frame", fcnt, 0);
        rst = 1'b1;
        #1;
        check("arst_value", value, 16'h0000);
        check("arst_ok", digit_ok, 4'h0);
        check("arst_err_digit", err_digit, 3'd0);
        check("arst_frame", frame_valid, 1'b0);
        check("arst_err", err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        fcnt = 0;
        run(4'b0100, 7'h7D, 6);
        run(4'b1000, 7'h71, 6);
        check("post_rst_no_frame", fcnt, 0);
        check("post_rst_value", value, 16'hF600);
        check("post_rst_ok", digit_ok, 4'hC);
        run(4'b0001, 7'h3F, 6);
        run(4'b0010, 7'h06, 6);
        check("post_rst_frame", fcnt, 1);
        check("post_rst_value2", value, 16'hF610);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
